// File: rtl/ram_arb_rr.sv
// Round-robin arbiter giving NPORT Wishbone-style masters shared access to one RAM slave port.
// Define RAM_ARB_TIMEOUT_EN to abort grants whose slave stalls for TIMEOUT cycles.
module ram_arb_rr #(
  parameter int NPORT   = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [NPORT-1:0]       m_cyc,
  input  logic [NPORT-1:0]       m_we,
  input  logic [4*NPORT-1:0]     m_sel,
  input  logic [WIDTH*NPORT-1:0] m_adr,
  input  logic [32*NPORT-1:0]    m_dat,
  output logic [NPORT-1:0]       m_ack,
  output logic [NPORT-1:0]       m_err,
  output logic [32*NPORT-1:0]    m_rdt,
  output logic                   x_cyc,
  output logic                   x_we,
  output logic [3:0]             x_sel,
  output logic [WIDTH-1:0]       x_adr,
  output logic [31:0]            x_dat,
  input  logic                   x_ack,
  input  logic [31:0]            x_rdt
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   g_reg, g_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   win;
  logic            granted;
  logic            timeout_hit;
  logic            ack_int;

  logic [3:0]       sel_arr [NPORT];
  logic [WIDTH-1:0] adr_arr [NPORT];
  logic [31:0]      dat_arr [NPORT];

  // First requester found scanning upward from ptr+1, wrapping at NPORT.
  function automatic logic [IW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = IW'((int'(ptr) + k) % NPORT);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win = rr_pick(m_cyc, ptr_reg);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      ptr_reg   <= IW'(NPORT - 1);
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|m_cyc) begin
          state_next = GRANT;
          g_next     = win;
          ptr_next   = win;
        end
      end
      GRANT: begin
        if (!m_cyc[g_reg] || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  for (gi = 0; gi < NPORT; gi++) begin : g_port
    logic is_g;
    assign is_g         = (g_reg == IW'(gi));
    assign sel_arr[gi]  = m_sel[4*gi +: 4];
    assign adr_arr[gi]  = m_adr[WIDTH*gi +: WIDTH];
    assign dat_arr[gi]  = m_dat[32*gi +: 32];
    assign m_ack[gi]    = ack_int && is_g;
    assign m_err[gi]    = timeout_hit && is_g;
    assign m_rdt[32*gi +: 32] = (ack_int && is_g && !m_we[gi]) ? x_rdt : 32'd0;
  end

  // Slave-side buses are forced to zero whenever no transfer is presented.
  assign granted = (state_reg == GRANT);
  assign x_cyc   = granted && m_cyc[g_reg];
  assign x_we    = x_cyc && m_we[g_reg];
  assign x_sel   = x_cyc ? sel_arr[g_reg] : 4'd0;
  assign x_adr   = x_cyc ? adr_arr[g_reg] : '0;
  assign x_dat   = (x_cyc && m_we[g_reg]) ? dat_arr[g_reg] : 32'd0;
  assign ack_int = x_cyc && x_ack && !timeout_hit;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_reg, tmo_next;

  assign timeout_hit = granted && (tmo_reg == CW'(TIMEOUT));

  always_comb begin
    tmo_next = tmo_reg;
    if (!granted || (state_next != GRANT) || x_ack) tmo_next = '0;
    else if (x_cyc)                                  tmo_next = tmo_reg + 1'b1;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) tmo_reg <= '0;
    else        tmo_reg <= tmo_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arb_rr.sv
// Self-checking bench for ram_arb_rr: directed vector table, corner-case sequences and
// randomized traffic compared against an owner/last-winner reference model.
module tb_ram_arb_rr;
  localparam int N   = 4;
  localparam int W   = 10;
  localparam int TMO = 8;

  logic           wb_clk = 1'b0;
  logic           wb_rst;
  logic [N-1:0]   m_cyc, m_we;
  logic [4*N-1:0] m_sel;
  logic [W*N-1:0] m_adr;
  logic [32*N-1:0] m_dat;
  logic [N-1:0]   m_ack, m_err;
  logic [32*N-1:0] m_rdt;
  logic           x_cyc, x_we;
  logic [3:0]     x_sel;
  logic [W-1:0]   x_adr;
  logic [31:0]    x_dat;
  logic           x_ack;
  logic [31:0]    x_rdt;

  ram_arb_rr #(.NPORT(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
    .m_ack(m_ack), .m_err(m_err), .m_rdt(m_rdt),
    .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
    .x_ack(x_ack), .x_rdt(x_rdt)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the slave (-1 = nobody), who won last, stall count.
  int owner, last, stall;
  logic            e_xcyc, e_xwe;
  logic [3:0]      e_xsel;
  logic [W-1:0]    e_xadr;
  logic [31:0]     e_xdat;
  logic [N-1:0]    e_ack, e_err;
  logic [32*N-1:0] e_rdt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tmo_hit();
`ifdef RAM_ARB_TIMEOUT_EN
    return (owner >= 0) && (stall == TMO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    owner = -1;
    last  = N - 1;
    stall = 0;
  endtask

  task automatic model_eval();
    bit hit;
    e_xcyc = 0; e_xwe = 0; e_xsel = 0; e_xadr = 0; e_xdat = 0;
    e_ack = 0; e_err = 0; e_rdt = 0;
    hit = tmo_hit();
    if (owner >= 0) begin
      if (m_cyc[owner]) begin
        e_xcyc = 1'b1;
        e_xwe  = m_we[owner];
        e_xsel = m_sel[4*owner +: 4];
        e_xadr = m_adr[W*owner +: W];
        if (m_we[owner]) e_xdat = m_dat[32*owner +: 32];
        if (x_ack && !hit) begin
          e_ack[owner] = 1'b1;
          if (!m_we[owner]) e_rdt[32*owner +: 32] = x_rdt;
        end
      end
      e_err[owner] = hit;
    end
  endtask

  task automatic model_update();
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if (owner < 0 && m_cyc[i]) begin
          owner = i;
          last  = i;
        end
      end
      stall = 0;
    end else if (tmo_hit() || !m_cyc[owner]) begin
      owner = -1;
      stall = 0;
    end else if (x_ack) begin
      stall = 0;
    end else begin
      stall++;
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("x_cyc", x_cyc, e_xcyc);
    chk("x_we", x_we, e_xwe);
    chk("x_sel", x_sel, e_xsel);
    chk("x_adr", x_adr, e_xadr);
    chk("x_dat", x_dat, e_xdat);
    chk("m_ack", m_ack, e_ack);
    chk("m_err", m_err, e_err);
    chk("m_rdt", m_rdt, e_rdt);
  endtask

  task automatic at_neg();
    @(negedge wb_clk);
    check_model();
  endtask

  task automatic adv();
    if (wb_rst) model_reset();
    else        model_update();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    x_ack = 1'b0; x_rdt = '0;
  endtask

  task automatic set_port(input int p, input bit cyc, input bit we, input logic [3:0] sel,
                          input logic [W-1:0] adr, input logic [31:0] dat);
    m_cyc[p] = cyc;
    m_we[p]  = we;
    m_sel[4*p +: 4]  = sel;
    m_adr[W*p +: W]  = adr;
    m_dat[32*p +: 32] = dat;
  endtask

  typedef struct {
    logic [3:0]   cyc;
    logic [3:0]   we;
    int           p;
    logic [3:0]   sel;
    logic [W-1:0] adr;
    logic [31:0]  dat;
    logic         ack;
    logic [31:0]  rdt;
    logic         e_cyc;
    logic         e_we;
    logic [3:0]   e_sel;
    logic [W-1:0] e_adr;
    logic [31:0]  e_dat;
    logic [3:0]   e_ack;
    logic [31:0]  e_prdt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [$];
    int exp_order [5];
    logic [N-1:0] ack_now;
    logic [127:0] er;
    int stalled, errs, acks_seen, got3;

    tbl[0] = '{4'b0001, 4'b0000, 0, 4'hF, 10'h010, 32'h0, 1'b0, 32'h12345678,
               1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 4'b0000, 32'h0};
    tbl[1] = '{4'b0001, 4'b0000, 0, 4'hF, 10'h010, 32'h0, 1'b1, 32'h12345678,
               1'b1, 1'b0, 4'hF, 10'h010, 32'h0, 4'b0001, 32'h12345678};
    tbl[2] = '{4'b0000, 4'b0000, 0, 4'hF, 10'h010, 32'h0, 1'b1, 32'h12345678,
               1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 4'b0000, 32'h0};
    tbl[3] = '{4'b1000, 4'b1000, 3, 4'b0011, 10'h155, 32'hDEADBEEF, 1'b0, 32'hFFFFFFFF,
               1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 4'b0000, 32'h0};
    tbl[4] = '{4'b1000, 4'b1000, 3, 4'b0011, 10'h155, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFF,
               1'b1, 1'b1, 4'b0011, 10'h155, 32'hDEADBEEF, 4'b1000, 32'h0};
    tbl[5] = '{4'b0000, 4'b0000, 3, 4'h0, 10'h000, 32'h0, 1'b1, 32'h00000055,
               1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 4'b0000, 32'h0};
    tbl[6] = '{4'b0000, 4'b0000, 3, 4'h0, 10'h000, 32'h0, 1'b1, 32'h00000055,
               1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 4'b0000, 32'h0};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with every master requesting: all outputs must stay zero.
    clear_inputs();
    m_cyc  = '1;
    x_ack  = 1'b1;
    wb_rst = 1'b1;
    model_reset();
    at_neg();
    chk("reset x_cyc", x_cyc, 1'b0);
    chk("reset m_ack", m_ack, '0);
    adv();
    at_neg();
    adv();
    wb_rst = 1'b0;
    clear_inputs();

    // Directed vector table: single read on port 0, write on port 3, stray acks.
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      m_cyc = tbl[i].cyc;
      m_we  = tbl[i].we;
      m_sel[4*tbl[i].p +: 4]   = tbl[i].sel;
      m_adr[W*tbl[i].p +: W]   = tbl[i].adr;
      m_dat[32*tbl[i].p +: 32] = tbl[i].dat;
      x_ack = tbl[i].ack;
      x_rdt = tbl[i].rdt;
      at_neg();
      er = '0;
      er[32*tbl[i].p +: 32] = tbl[i].e_prdt;
      $display("vec %0d: x_cyc=%0b x_adr=%0h m_ack=%b m_rdt=%0h", i, x_cyc, x_adr, m_ack, m_rdt);
      chk($sformatf("vec%0d x_cyc", i), x_cyc, tbl[i].e_cyc);
      chk($sformatf("vec%0d x_we", i), x_we, tbl[i].e_we);
      chk($sformatf("vec%0d x_sel", i), x_sel, tbl[i].e_sel);
      chk($sformatf("vec%0d x_adr", i), x_adr, tbl[i].e_adr);
      chk($sformatf("vec%0d x_dat", i), x_dat, tbl[i].e_dat);
      chk($sformatf("vec%0d m_ack", i), m_ack, tbl[i].e_ack);
      chk($sformatf("vec%0d m_rdt", i), m_rdt, er);
      adv();
    end

    // All four request; each drops for one cycle after its ack -> order 0,1,2,3,0.
    wb_rst = 1'b1;
    model_reset();
    at_neg();
    adv();
    wb_rst = 1'b0;
    clear_inputs();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 4'hF, W'(10'h100 + p), 32'h0);
    x_ack = 1'b1;
    x_rdt = 32'h0BADF00D;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      at_neg();
      ack_now = m_ack;
      for (int p = 0; p < N; p++) if (ack_now[p]) order.push_back(p);
      adv();
      m_cyc = 4'hF & ~ack_now;
    end
    chk("grant count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) begin
      $display("grant %0d -> port %0d", i, order[i]);
      chk($sformatf("grant order %0d", i), order[i], exp_order[i]);
    end
    clear_inputs();
    at_neg(); adv();
    at_neg(); adv();

    // Port 2 holds the grant over three writes while port 1 waits.
    set_port(2, 1'b1, 1'b1, 4'hF, 10'h2AA, 32'hA5A5A5A5);
    at_neg(); adv();
    set_port(1, 1'b1, 1'b0, 4'hF, 10'h011, 32'h0);
    x_ack = 1'b1;
    x_rdt = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      $display("p2 write %0d: x_dat=%0h m_ack=%b", i, x_dat, m_ack);
      chk("p2 write x_dat", x_dat, 32'hA5A5A5A5);
      chk("p2 write m_ack", m_ack, 4'b0100);
      chk("p1 waiting m_rdt", m_rdt[63:32], 32'h0);
      adv();
    end
    m_cyc[2] = 1'b0;
    x_ack = 1'b0;
    at_neg();
    chk("p2 release x_cyc", x_cyc, 1'b0);
    adv();
    at_neg();
    adv();
    x_ack = 1'b1;
    x_rdt = 32'hCAFEF00D;
    at_neg();
    $display("p1 grant: x_adr=%0h m_ack=%b", x_adr, m_ack);
    chk("p1 granted m_ack", m_ack, 4'b0010);
    chk("p1 granted x_adr", x_adr, 10'h011);
    chk("p1 granted m_rdt", m_rdt[63:32], 32'hCAFEF00D);
    adv();
    clear_inputs();
    at_neg(); adv();

    // Reset mid-read on port 0 while port 1 also requests; port 0 must win first afterwards.
    set_port(0, 1'b1, 1'b0, 4'hF, 10'h0C0, 32'h0);
    at_neg(); adv();
    set_port(1, 1'b1, 1'b0, 4'hF, 10'h0C1, 32'h0);
    x_ack = 1'b1;
    x_rdt = 32'h13579BDF;
    at_neg();
    #1;
    wb_rst = 1'b1;
    model_reset();
    #1;
    $display("mid-read reset: x_cyc=%0b m_ack=%b m_rdt=%0h", x_cyc, m_ack, m_rdt);
    chk("rst x_cyc", x_cyc, 1'b0);
    chk("rst x_adr", x_adr, '0);
    chk("rst m_ack", m_ack, '0);
    chk("rst m_rdt", m_rdt, '0);
    adv();
    at_neg();
    adv();
    wb_rst = 1'b0;
    at_neg();
    adv();
    at_neg();
    chk("post-reset winner", m_ack, 4'b0001);
    adv();
    clear_inputs();
    at_neg(); adv();
    at_neg(); adv();

`ifdef RAM_ARB_TIMEOUT_EN
    // Slave never acks: one err pulse after TMO stalled cycles, then port 3 is served.
    set_port(1, 1'b1, 1'b0, 4'hF, 10'h0A1, 32'h0);
    set_port(3, 1'b1, 1'b0, 4'hF, 10'h0A3, 32'h0);
    x_ack = 1'b0;
    stalled = 0; errs = 0; acks_seen = 0; got3 = 0;
    for (int c = 0; c < 40 && got3 == 0; c++) begin
      at_neg();
      if (m_err != 0) begin
        errs++;
        chk("tmo err port", m_err, 4'b0010);
        chk("tmo stalled cycles", stalled, TMO);
      end else if (x_cyc && x_adr == 10'h0A1) begin
        stalled++;
      end
      if (m_ack != 0) acks_seen++;
      if (x_cyc && x_adr == 10'h0A3) got3 = 1;
      adv();
    end
    $display("timeout: stalled=%0d errs=%0d acks=%0d next=port3:%0d", stalled, errs, acks_seen, got3);
    chk("tmo err pulses", errs, 1);
    chk("tmo no ack", acks_seen, 0);
    chk("tmo next grant", got3, 1);
    clear_inputs();
    at_neg(); adv();
    at_neg(); adv();
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(3) == 0) m_cyc[p] = ~m_cyc[p];
        m_we[p] = 1'($urandom_range(1));
        m_sel[4*p +: 4]   = 4'($urandom);
        m_adr[W*p +: W]   = W'($urandom);
        m_dat[32*p +: 32] = $urandom;
      end
      x_ack = 1'($urandom_range(1));
      x_rdt = $urandom;
      at_neg();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arb_rr.md
RAM_ARB_RR -- requirements
Module: ram_arb_rr

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of master ports (2..8).
REQ-002 SHALL have parameter WIDTH, default 10, word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 64, stall limit in cycles (used only with RAM_ARB_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- wb_clk  in  1  clock.
- wb_rst  in  1  asynchronous active-high reset.
- m_cyc  in  NPORT  per-port cycle request.
- m_we  in  NPORT  per-port write enable.
- m_sel  in  4*NPORT  byte selects; port i occupies bits [4i+3:4i].
- m_adr  in  WIDTH*NPORT  addresses; port i occupies bits [WIDTH*i+WIDTH-1:WIDTH*i].
- m_dat  in  32*NPORT  write data; port i occupies bits [32i+31:32i].
- m_ack  out  NPORT  per-port acknowledge.
- m_err  out  NPORT  per-port timeout error pulse.
- m_rdt  out  32*NPORT  per-port read data.
- x_cyc, x_we  out  1  slave cycle and write enable.
- x_sel  out  4  slave byte selects.
- x_adr  out  WIDTH  slave address.
- x_dat  out  32  slave write data.
- x_ack  in  1  slave acknowledge.
- x_rdt  in  32  slave read data.

Function
REQ-006 SHALL implement two states: IDLE and GRANT; GRANT carries a registered index g.
REQ-007 In IDLE with any m_cyc high, SHALL pick the winner in round-robin order, starting at index ptr+1 mod NPORT, and enter GRANT with g set to the winner on the next clock edge.
REQ-008 On entering GRANT, SHALL set ptr to g.
REQ-009 In IDLE with no m_cyc high, SHALL remain in IDLE.
REQ-010 x_cyc SHALL equal (state==GRANT) & m_cyc[g], giving one cycle of grant latency from request.
REQ-011 In GRANT, SHALL drive x_we, x_sel and x_adr from port g.
REQ-012 x_dat SHALL equal m_dat[g] when m_we[g] is high, else 0.
REQ-013 When x_cyc is low, x_we, x_sel, x_adr and x_dat SHALL be 0.
REQ-014 m_ack[g] SHALL equal x_ack & x_cyc, combinationally; all other m_ack bits SHALL be 0.
REQ-015 m_rdt for port g SHALL equal x_rdt when m_ack[g] is high and m_we[g] is low; it SHALL be 0 otherwise and 0 for every other port.
REQ-016 The grant SHALL be held while m_cyc[g] remains high, so back-to-back transfers by one master stay on the grant.
REQ-017 When m_cyc[g] is sampled low in GRANT, SHALL return to IDLE.
REQ-018 A non-granted master SHALL see m_ack=0 and m_rdt=0 until it is granted.
REQ-019 A request from a port other than g that arrives in the same cycle as the release of g SHALL be arbitrated in the following IDLE cycle.
REQ-020 x_ack received while x_cyc is low SHALL be ignored.

Reset
REQ-021 wb_rst high SHALL asynchronously force state=IDLE, ptr=NPORT-1 (so port 0 wins first) and the timeout counter to 0.
REQ-022 During reset, all outputs SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no ack or err issued.

Configuration
REQ-024 With macro RAM_ARB_TIMEOUT_EN defined, SHALL count GRANT cycles in which x_cyc is high and x_ack is low.
REQ-025 The timeout counter SHALL clear on x_ack and on leaving GRANT.
REQ-026 When the count reaches TIMEOUT, SHALL pulse m_err[g] for one cycle, suppress m_ack, and return to IDLE, with ptr already equal to g so other requesters win next.
REQ-027 Without RAM_ARB_TIMEOUT_EN, SHALL omit the counter, tie m_err to 0 and ignore TIMEOUT.

Verification
REQ-028 Bench SHALL cover: reset, then m_cyc=4'b0001, read of adr 0x010 -> x_cyc rises 1 cycle later, x_adr=0x010, m_ack[0] equals x_ack, m_rdt[0]=x_rdt=0x12345678, other m_rdt=0.
REQ-029 Bench SHALL cover: m_cyc=4'b1111 held, each master drops cyc after one ack -> grant order 0,1,2,3,0.
REQ-030 Bench SHALL cover: port 2 holds cyc across 3 writes while port 1 requests -> port 1 waits, granted only after port 2 drops; x_dat matches port 2 data 0xA5A5A5A5 on writes.
REQ-031 Bench SHALL cover: write from port 3 with sel=4'b0011 -> x_we=1, x_sel=4'b0011, m_rdt[3]=0 on ack.
REQ-032 Bench SHALL cover: with RAM_ARB_TIMEOUT_EN and TIMEOUT=8, slave never acks -> m_err[g] pulses once after 8 stalled cycles, m_ack stays 0, next requester granted.
REQ-033 Bench SHALL cover: wb_rst asserted mid-read -> outputs 0 immediately, port 0 wins first after release.
